// File: rtl/sb_decoder.sv
// SB bus address decoder and response mux with a built-in two-cycle ERROR default slave.
// Optional watchdog abort of a stalled slave when SB_DEC_TIMEOUT_EN is defined.
module sb_decoder #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        sb_clk,
  input  logic        sb_reset,
  input  logic [31:0] sb_addr,
  input  logic [1:0]  sb_trans,
  output logic        sb_sel_s1,
  output logic        sb_sel_s2,
  output logic        sb_sel_s3,
  input  logic        sb_ready_s1,
  input  logic        sb_ready_s2,
  input  logic        sb_ready_s3,
  input  logic [1:0]  sb_resp_s1,
  input  logic [1:0]  sb_resp_s2,
  input  logic [1:0]  sb_resp_s3,
  input  logic [31:0] sb_data_s1,
  input  logic [31:0] sb_data_s2,
  input  logic [31:0] sb_data_s3,
  input  logic [1:0]  sb_split_s1,
  input  logic [1:0]  sb_split_s2,
  input  logic [1:0]  sb_split_s3,
  output logic        sb_ready,
  output logic [1:0]  sb_resp,
  output logic [31:0] sb_rdata,
  output logic [1:0]  sb_split,
  output logic        sb_dec_timeout
);

  typedef enum logic [1:0] {DS_NORM = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_t;
  typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_S1 = 2'd1, SEL_S2 = 2'd2, SEL_S3 = 2'd3} sel_t;

  localparam logic [1:0] RESP_OKAY  = 2'd1;
  localparam logic [1:0] RESP_ERROR = 2'd2;
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  ds_state_t state_q, state_d;
  sel_t      dsel_q, dsel_d;
  sel_t      dec_sel;
  logic      dec_unmapped;
  logic      ready_mux;
  logic      wd_fire;

  // Only NONSEQ/SEQ (trans[1]=1) carry an address; low 12 bits are the in-slave offset.
  always_comb begin
    dec_sel      = SEL_NONE;
    dec_unmapped = 1'b0;
    if (sb_trans[1]) begin
      if (sb_addr[31:14] != 18'd0 || sb_addr[13:12] == 2'd0) begin
        dec_unmapped = 1'b1;
      end else begin
        dec_sel = sel_t'(sb_addr[13:12]);
      end
    end
  end

  always_comb begin
    ready_mux = 1'b1;
    sb_resp   = RESP_OKAY;
    sb_rdata  = 32'd0;
    case (state_q)
      DS_ERR1: begin
        ready_mux = 1'b0;
        sb_resp   = RESP_ERROR;
      end
      DS_ERR2: begin
        ready_mux = 1'b1;
        sb_resp   = RESP_ERROR;
      end
      default: begin
        case (dsel_q)
          SEL_S1: begin
            ready_mux = sb_ready_s1;
            sb_resp   = sb_resp_s1;
            sb_rdata  = sb_data_s1;
          end
          SEL_S2: begin
            ready_mux = sb_ready_s2;
            sb_resp   = sb_resp_s2;
            sb_rdata  = sb_data_s2;
          end
          SEL_S3: begin
            ready_mux = sb_ready_s3;
            sb_resp   = sb_resp_s3;
            sb_rdata  = sb_data_s3;
          end
          default: begin
            ready_mux = 1'b1;
            sb_resp   = RESP_OKAY;
            sb_rdata  = 32'd0;
          end
        endcase
      end
    endcase
  end

  assign sb_ready = ready_mux;
  assign sb_split = sb_split_s1 | sb_split_s2 | sb_split_s3;

`ifdef SB_DEC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                 wd_wait;

  // A ready slave in the final cycle clears wd_wait, so the slave wins over the abort.
  assign wd_wait = (state_q == DS_NORM) && (dsel_q != SEL_NONE) && !ready_mux;
  assign wd_fire = wd_wait && (wd_cnt_q == TMO_LAST);

  always_comb begin
    wd_cnt_d = '0;
    if (wd_wait && !wd_fire) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sb_clk or posedge sb_reset) begin
    if (sb_reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic [TIMEOUT_W-1:0] unused_tmo;
  assign unused_tmo = TMO_LAST;
  assign wd_fire    = 1'b0;
`endif

  assign sb_dec_timeout = wd_fire;

  always_comb begin
    state_d = state_q;
    dsel_d  = dsel_q;
    case (state_q)
      DS_ERR1: begin
        state_d = DS_ERR2;
        dsel_d  = SEL_NONE;
      end
      default: begin
        if (wd_fire) begin
          state_d = DS_ERR1;
          dsel_d  = SEL_NONE;
        end else if (ready_mux) begin
          // ERR2 presents ready=1, so it loads the next address like DS_NORM.
          if (dec_unmapped) begin
            state_d = DS_ERR1;
            dsel_d  = SEL_NONE;
          end else begin
            state_d = DS_NORM;
            dsel_d  = dec_sel;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sb_clk or posedge sb_reset) begin
    if (sb_reset) begin
      state_q <= DS_NORM;
      dsel_q  <= SEL_NONE;
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
    end
  end

  assign sb_sel_s1 = (dsel_q == SEL_S1);
  assign sb_sel_s2 = (dsel_q == SEL_S2);
  assign sb_sel_s3 = (dsel_q == SEL_S3);

  logic unused_in;
  assign unused_in = ^{sb_addr[11:0], sb_trans[0]};

endmodule

// File: tb/tb_sb_decoder.sv
// Directed self-checking bench for sb_decoder (watchdog scenario built with SB_DEC_TIMEOUT_EN).
module tb_sb_decoder;

  logic        sb_clk = 1'b0;
  logic        sb_reset;
  logic [31:0] sb_addr;
  logic [1:0]  sb_trans;
  logic        sb_sel_s1, sb_sel_s2, sb_sel_s3;
  logic        sb_ready_s1, sb_ready_s2, sb_ready_s3;
  logic [1:0]  sb_resp_s1, sb_resp_s2, sb_resp_s3;
  logic [31:0] sb_data_s1, sb_data_s2, sb_data_s3;
  logic [1:0]  sb_split_s1, sb_split_s2, sb_split_s3;
  logic        sb_ready;
  logic [1:0]  sb_resp;
  logic [31:0] sb_rdata;
  logic [1:0]  sb_split;
  logic        sb_dec_timeout;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  sb_decoder #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(8)) dut (
    .sb_clk(sb_clk), .sb_reset(sb_reset), .sb_addr(sb_addr), .sb_trans(sb_trans),
    .sb_sel_s1(sb_sel_s1), .sb_sel_s2(sb_sel_s2), .sb_sel_s3(sb_sel_s3),
    .sb_ready_s1(sb_ready_s1), .sb_ready_s2(sb_ready_s2), .sb_ready_s3(sb_ready_s3),
    .sb_resp_s1(sb_resp_s1), .sb_resp_s2(sb_resp_s2), .sb_resp_s3(sb_resp_s3),
    .sb_data_s1(sb_data_s1), .sb_data_s2(sb_data_s2), .sb_data_s3(sb_data_s3),
    .sb_split_s1(sb_split_s1), .sb_split_s2(sb_split_s2), .sb_split_s3(sb_split_s3),
    .sb_ready(sb_ready), .sb_resp(sb_resp), .sb_rdata(sb_rdata), .sb_split(sb_split),
    .sb_dec_timeout(sb_dec_timeout)
  );

  always #5 sb_clk = ~sb_clk;

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic test_reset();
    sb_reset = 1'b1;
    step();
    step();
    chk_cnt++; if ({sb_sel_s3, sb_sel_s2, sb_sel_s1} !== 3'b000) $display("FAIL reset_sel got %b exp 000", {sb_sel_s3, sb_sel_s2, sb_sel_s1}); else pass_cnt++;
    chk_cnt++; if (sb_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", sb_ready); else pass_cnt++;
    chk_cnt++; if (sb_resp !== 2'd1) $display("FAIL reset_resp got %0d exp 1", sb_resp); else pass_cnt++;
    chk_cnt++; if (sb_rdata !== 32'd0) $display("FAIL reset_rdata got %h exp 0", sb_rdata); else pass_cnt++;
    chk_cnt++; if (sb_split !== 2'b00) $display("FAIL reset_split got %b exp 00", sb_split); else pass_cnt++;
    chk_cnt++; if (sb_dec_timeout !== 1'b0) $display("FAIL reset_timeout got %b exp 0", sb_dec_timeout); else pass_cnt++;
    sb_reset = 1'b0;
  endtask

  task automatic test_read_s2();
    sb_addr  = 32'h0000_2010;
    sb_trans = 2'd2;
    #1;
    chk_cnt++; if ({sb_sel_s3, sb_sel_s2, sb_sel_s1} !== 3'b000) $display("FAIL s2_no_comb_sel got %b exp 000", {sb_sel_s3, sb_sel_s2, sb_sel_s1}); else pass_cnt++;
    step();
    chk_cnt++; if ({sb_sel_s3, sb_sel_s2, sb_sel_s1} !== 3'b010) $display("FAIL s2_sel got %b exp 010", {sb_sel_s3, sb_sel_s2, sb_sel_s1}); else pass_cnt++;
    chk_cnt++; if (sb_rdata !== 32'hCAFE_0001) $display("FAIL s2_rdata got %h exp cafe0001", sb_rdata); else pass_cnt++;
    chk_cnt++; if (sb_resp !== 2'd1) $display("FAIL s2_resp got %0d exp 1", sb_resp); else pass_cnt++;
    sb_trans = 2'd0;
    step();
    chk_cnt++; if ({sb_sel_s3, sb_sel_s2, sb_sel_s1} !== 3'b000) $display("FAIL s2_idle_sel got %b exp 000", {sb_sel_s3, sb_sel_s2, sb_sel_s1}); else pass_cnt++;
  endtask

  task automatic test_unmapped();
    sb_addr  = 32'h0001_0000;
    sb_trans = 2'd2;
    step();
    chk_cnt++; if ({sb_sel_s3, sb_sel_s2, sb_sel_s1} !== 3'b000) $display("FAIL unm_sel got %b exp 000", {sb_sel_s3, sb_sel_s2, sb_sel_s1}); else pass_cnt++;
    chk_cnt++; if ({sb_ready, sb_resp} !== 3'b0_10) $display("FAIL unm_err1 got ready=%b resp=%0d exp ready=0 resp=2", sb_ready, sb_resp); else pass_cnt++;
    sb_trans = 2'd0;
    step();
    chk_cnt++; if ({sb_ready, sb_resp} !== 3'b1_10) $display("FAIL unm_err2 got ready=%b resp=%0d exp ready=1 resp=2", sb_ready, sb_resp); else pass_cnt++;
    step();
    chk_cnt++; if ({sb_ready, sb_resp} !== 3'b1_01) $display("FAIL unm_norm got ready=%b resp=%0d exp ready=1 resp=1", sb_ready, sb_resp); else pass_cnt++;
    // index 0 inside the low 16 KB is also unmapped
    sb_addr  = 32'h0000_0100;
    sb_trans = 2'd3;
    step();
    chk_cnt++; if ({sb_ready, sb_resp} !== 3'b0_10) $display("FAIL unm_idx0 got ready=%b resp=%0d exp ready=0 resp=2", sb_ready, sb_resp); else pass_cnt++;
    sb_trans = 2'd0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    sb_ready_s3 = 1'b0;
    sb_addr     = 32'h0000_3000;
    sb_trans    = 2'd2;
    step();
    chk_cnt++; if (sb_ready !== 1'b0) $display("FAIL stall_ready got %b exp 0", sb_ready); else pass_cnt++;
    sb_addr = 32'h0000_1000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_cnt++; if ({sb_sel_s3, sb_sel_s2, sb_sel_s1} !== 3'b100) $display("FAIL stall_hold%0d got %b exp 100", i, {sb_sel_s3, sb_sel_s2, sb_sel_s1}); else pass_cnt++;
    end
    sb_ready_s3 = 1'b1;
    #1;
    chk_cnt++; if ({sb_ready, sb_rdata} !== {1'b1, 32'h3333_0003}) $display("FAIL stall_done got ready=%b rdata=%h exp ready=1 rdata=33330003", sb_ready, sb_rdata); else pass_cnt++;
    step();
    chk_cnt++; if ({sb_sel_s3, sb_sel_s2, sb_sel_s1} !== 3'b001) $display("FAIL b2b_sel got %b exp 001", {sb_sel_s3, sb_sel_s2, sb_sel_s1}); else pass_cnt++;
    sb_trans = 2'd0;
    step();
  endtask

  task automatic test_split_resp();
    sb_split_s1 = 2'b01;
    sb_split_s3 = 2'b10;
    #1;
    chk_cnt++; if (sb_split !== 2'b11) $display("FAIL split_or got %b exp 11", sb_split); else pass_cnt++;
    sb_split_s1 = 2'b00;
    sb_split_s3 = 2'b00;
    sb_addr  = 32'h0000_1004;
    sb_trans = 2'd2;
    step();
    sb_trans   = 2'd0;
    sb_resp_s1 = 2'd3;
    #1;
    chk_cnt++; if (sb_resp !== 2'd3) $display("FAIL resp_split got %0d exp 3", sb_resp); else pass_cnt++;
    sb_resp_s1 = 2'd0;
    #1;
    chk_cnt++; if (sb_resp !== 2'd0) $display("FAIL resp_zero got %0d exp 0", sb_resp); else pass_cnt++;
    sb_resp_s1 = 2'd1;
    step();
  endtask

  task automatic test_reset_in_err();
    sb_addr  = 32'h0001_0000;
    sb_trans = 2'd2;
    step();
    sb_trans = 2'd0;
    chk_cnt++; if (sb_ready !== 1'b0) $display("FAIL rerr_in_err1 got %b exp 0", sb_ready); else pass_cnt++;
    #1 sb_reset = 1'b1;
    #1;
    chk_cnt++; if ({sb_ready, sb_resp, sb_sel_s3, sb_sel_s2, sb_sel_s1} !== 6'b1_01_000) $display("FAIL rerr_async got %b exp 101000", {sb_ready, sb_resp, sb_sel_s3, sb_sel_s2, sb_sel_s1}); else pass_cnt++;
    step();
    sb_reset = 1'b0;
    sb_addr  = 32'h0000_3000;
    sb_trans = 2'd2;
    step();
    sb_trans = 2'd0;
    chk_cnt++; if ({sb_sel_s3, sb_sel_s2, sb_sel_s1} !== 3'b100) $display("FAIL rerr_s3 got %b exp 100", {sb_sel_s3, sb_sel_s2, sb_sel_s1}); else pass_cnt++;
    step();
  endtask

  task automatic test_watchdog();
    sb_ready_s1 = 1'b0;
    sb_addr     = 32'h0000_1000;
    sb_trans    = 2'd2;
    step();
    sb_trans = 2'd0;
    // wait cycle 1 is now; advance to wait cycle 7
    for (int i = 0; i < 6; i++) step();
    chk_cnt++; if (sb_dec_timeout !== 1'b0) $display("FAIL wd_early got %b exp 0", sb_dec_timeout); else pass_cnt++;
    step();
`ifdef SB_DEC_TIMEOUT_EN
    chk_cnt++; if (sb_dec_timeout !== 1'b1) $display("FAIL wd_pulse got %b exp 1", sb_dec_timeout); else pass_cnt++;
    step();
    chk_cnt++; if ({sb_sel_s1, sb_ready, sb_resp, sb_dec_timeout} !== 5'b0_0_10_0) $display("FAIL wd_err1 got %b exp 00100", {sb_sel_s1, sb_ready, sb_resp, sb_dec_timeout}); else pass_cnt++;
    step();
    chk_cnt++; if ({sb_ready, sb_resp} !== 3'b1_10) $display("FAIL wd_err2 got %b exp 110", {sb_ready, sb_resp}); else pass_cnt++;
`else
    chk_cnt++; if ({sb_sel_s1, sb_dec_timeout} !== 2'b10) $display("FAIL wd_off_hold got %b exp 10", {sb_sel_s1, sb_dec_timeout}); else pass_cnt++;
    sb_ready_s1 = 1'b1;
    step();
`endif
    sb_ready_s1 = 1'b1;
    step();
    chk_cnt++; if ({sb_sel_s1, sb_ready, sb_resp} !== 4'b0_1_01) $display("FAIL wd_recover got %b exp 0101", {sb_sel_s1, sb_ready, sb_resp}); else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout got hung exp finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    sb_reset    = 1'b1;
    sb_addr     = 32'd0;
    sb_trans    = 2'd0;
    sb_ready_s1 = 1'b1; sb_ready_s2 = 1'b1; sb_ready_s3 = 1'b1;
    sb_resp_s1  = 2'd1; sb_resp_s2  = 2'd1; sb_resp_s3  = 2'd1;
    sb_data_s1  = 32'h1111_0001;
    sb_data_s2  = 32'hCAFE_0001;
    sb_data_s3  = 32'h3333_0003;
    sb_split_s1 = 2'b00; sb_split_s2 = 2'b00; sb_split_s3 = 2'b00;
    test_reset();
    test_read_s2();
    test_unmapped();
    test_back_to_back();
    test_split_resp();
    test_reset_in_err();
    test_watchdog();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
